// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern generator.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_CHASE  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } led_mode_e;

    // Widest LED bank supported; users slice led_off() down to N_LED bits.
    localparam int unsigned LED_MAX = 64;

    function automatic logic [LED_MAX-1:0] led_off();
        return '1;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step prescaler: counts enabled cycles and strobes when the count reaches tick_div.
module led_prescaler #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] tick_div,
    output logic             tick,
    output logic             step
);

    logic [DIV_W-1:0] cnt_q;
    logic             step_q;

    // A clear (mode change) always wins over a pending compare hit.
    assign tick = enable && !clear && (cnt_q == tick_div);
    assign step = step_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else begin
            step_q <= tick;
            if (clear || tick) begin
                cnt_q <= '0;
            end else if (enable) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Active-low LED bank driver with static/chase/bounce/blink modes paced by a prescaler.
// Optional build macro LED_PWM_EN adds a 4-bit duty input for brightness control.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int unsigned N_LED = 8,
    parameter int unsigned SEL_W = (N_LED > 1) ? $clog2(N_LED) : 1,
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] switch,
`ifdef LED_PWM_EN
    input  logic [3:0]       duty,
`endif
    input  logic [DIV_W-1:0] tick_div,
    output logic             step,
    output logic [N_LED-1:0] led
);

    localparam logic [LED_MAX-1:0] OFF_WIDE    = led_off();
    localparam logic [N_LED-1:0]   LED_ALL_OFF = OFF_WIDE[N_LED-1:0];
    localparam logic [SEL_W-1:0]   LAST        = SEL_W'(N_LED - 1);

    function automatic logic [N_LED-1:0] onehot_n(input logic [SEL_W-1:0] idx);
        logic [N_LED-1:0] v;
        v = LED_ALL_OFF;
        for (int i = 0; i < int'(N_LED); i++) begin
            if (int'(idx) == i) v[i] = 1'b0;
        end
        return v;
    endfunction

    led_mode_e        mode_q;
    logic [SEL_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;      // 0 = up, 1 = down
    logic             phase_q, phase_d;
    logic [N_LED-1:0] led_q, led_d;
    logic [N_LED-1:0] pattern;
    logic             mode_chg;
    logic             tick;
    logic             lit_en;

    assign mode_chg = (mode != mode_q);

    led_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .clear    (mode_chg),
        .tick_div (tick_div),
        .tick     (tick),
        .step     (step)
    );

    always_comb begin
        pos_d   = pos_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        if (mode_chg) begin
            pos_d   = (int'(switch) < int'(N_LED)) ? switch : '0;
            dir_d   = 1'b0;
            phase_d = 1'b0;
        end else if (tick) begin
            unique case (mode_q)
                MODE_STATIC: ;
                MODE_CHASE:  pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
                MODE_BOUNCE: begin
                    // Reverse at each end without dwelling on the endpoint.
                    if (N_LED > 1) begin
                        if (!dir_q) begin
                            if (pos_q == LAST) begin
                                dir_d = 1'b1;
                                pos_d = pos_q - 1'b1;
                            end else begin
                                pos_d = pos_q + 1'b1;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = 1'b0;
                                pos_d = pos_q + 1'b1;
                            end else begin
                                pos_d = pos_q - 1'b1;
                            end
                        end
                    end
                end
                MODE_BLINK:  phase_d = ~phase_q;
                default:     ;
            endcase
        end
    end

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt_q <= '0;
        end else if (enable) begin
            pwm_cnt_q <= pwm_cnt_q + 4'd1;
        end
    end

    assign lit_en = (pwm_cnt_q < duty);
`else
    assign lit_en = 1'b1;
`endif

    always_comb begin
        unique case (mode_q)
            MODE_STATIC: pattern = onehot_n(switch);
            MODE_CHASE:  pattern = onehot_n(pos_q);
            MODE_BOUNCE: pattern = onehot_n(pos_q);
            MODE_BLINK:  pattern = phase_q ? onehot_n(switch) : LED_ALL_OFF;
            default:     pattern = LED_ALL_OFF;
        endcase
    end

    always_comb begin
        led_d = LED_ALL_OFF;
        if (enable) begin
            led_d = pattern | {N_LED{~lit_en}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= MODE_STATIC;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            phase_q <= 1'b0;
            led_q   <= LED_ALL_OFF;
        end else begin
            mode_q  <= led_mode_e'(mode);
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: reference model pushes expected led/step per edge.
module tb_led_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [2:0]  switch = 3'd0;
    logic [15:0] tick_div = 16'd0;
    logic        step;
    logic [7:0]  led;
    logic [1:0]  mode6 = 2'b00;
    logic [2:0]  switch6 = 3'd0;
    logic        step6;
    logic [5:0]  led6;
`ifdef LED_PWM_EN
    logic [3:0]  duty = 4'd15;
`endif

    led_pattern_gen #(.N_LED(8), .DIV_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .mode     (mode),
        .switch   (switch),
`ifdef LED_PWM_EN
        .duty     (duty),
`endif
        .tick_div (tick_div),
        .step     (step),
        .led      (led)
    );

    led_pattern_gen #(.N_LED(6), .DIV_W(16)) dut6 (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .mode     (mode6),
        .switch   (switch6),
`ifdef LED_PWM_EN
        .duty     (duty),
`endif
        .tick_div (tick_div),
        .step     (step6),
        .led      (led6)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] led;
        logic       step;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference model state, kept as plain integers.
    int          m_mode, m_pos, m_bk, m_phase, m_pwm;
    int unsigned m_cnt;
    bit          m_lit;
    int          bseq[14];

    function automatic logic [7:0] oh_n(input int i);
        logic [7:0] v;
        v = 8'hFF;
        if (i >= 0 && i < 8) v[i] = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_bk = 0; m_phase = 0; m_cnt = 0; m_pwm = 0; m_lit = 1'b1;
    endtask

    task automatic model_edge(output exp_t e);
        logic [7:0] pat;
        bit chg, tk;
        if (!rst) begin
            model_reset();
            e.led  = 8'hFF;
            e.step = 1'b0;
            return;
        end
        case (m_mode)
            0:       pat = oh_n(int'(switch));
            1, 2:    pat = oh_n(m_pos);
            default: pat = (m_phase != 0) ? oh_n(int'(switch)) : 8'hFF;
        endcase
        m_lit = 1'b1;
`ifdef LED_PWM_EN
        m_lit = (m_pwm < int'(duty));
        if (enable) m_pwm = (m_pwm + 1) % 16;
`endif
        if (!m_lit) pat = 8'hFF;
        e.led = enable ? pat : 8'hFF;
        chg = (int'(mode) != m_mode);
        tk  = enable && !chg && (m_cnt == 32'(tick_div));
        e.step = tk;
        if (chg) begin
            m_mode = int'(mode);
            m_pos = int'(switch);
            m_bk = m_pos;
            m_phase = 0;
            m_cnt = 0;
        end else if (tk) begin
            m_cnt = 0;
            case (m_mode)
                1: m_pos = (m_pos + 1) % 8;
                2: begin m_bk = (m_bk + 1) % 14; m_pos = bseq[m_bk]; end
                3: m_phase = 1 - m_phase;
                default: ;
            endcase
        end else if (enable) begin
            m_cnt = (m_cnt + 1) % 65536;
        end
    endtask

    task automatic cycle(input logic en, input logic [1:0] md, input logic [2:0] sw,
                         input logic [15:0] td);
        exp_t e;
        enable = en; mode = md; switch = sw; tick_div = td;
        @(posedge clk);
        #1;
        model_edge(e);
        q.push_back(e);
    endtask

    // Monitor: compare the DUT against the head of the queue on every falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (led !== e.led || step !== e.step) begin
                fails++;
                $display("FAIL scoreboard: led=%h step=%b, expected led=%h step=%b",
                         led, step, e.led, e.step);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] chase_exp [4];
        int         bounce_exp [16];
        int         n;
        int         lows;
        chase_exp = '{8'hBF, 8'h7F, 8'hFE, 8'hFD};
        bounce_exp = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        for (int k = 0; k < 8; k++) bseq[k] = k;
        for (int k = 8; k < 14; k++) bseq[k] = 14 - k;
        model_reset();

        #12;
        chk("reset_led", 32'(led), 32'hFF);
        chk("reset_step", 32'(step), 32'h0);
        chk("reset_led6", 32'(led6), 32'h3F);
        @(negedge clk);
        rst = 1'b1;

        // Static mode, including an out-of-range select on the 6-LED instance.
        switch6 = 3'd7;
        cycle(1'b1, 2'b00, 3'd3, 16'd0);
        chk("static_sw3", 32'(led), m_lit ? 32'hF7 : 32'hFF);
        chk("static6_sw7", 32'(led6), 32'h3F);
        switch6 = 3'd5;
        cycle(1'b1, 2'b00, 3'd0, 16'd0);
        chk("static_sw0", 32'(led), m_lit ? 32'hFE : 32'hFF);
        cycle(1'b1, 2'b00, 3'd0, 16'd0);
        chk("static6_sw5", 32'(led6), m_lit ? 32'h1F : 32'h3F);

        // Chase from 6 with a step every third cycle.
        cycle(1'b1, 2'b01, 3'd6, 16'd2);
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 2'b01, 3'd6, 16'd2);
            if ((i - 1) % 3 == 0)
                chk("chase_led", 32'(led), m_lit ? 32'(chase_exp[(i - 1) / 3]) : 32'hFF);
        end

        // Bounce with a step every cycle.
        cycle(1'b1, 2'b10, 3'd0, 16'd0);
        for (int k = 0; k < 16; k++) begin
            cycle(1'b1, 2'b10, 3'd0, 16'd0);
            chk("bounce_led", 32'(led), m_lit ? 32'(oh_n(bounce_exp[k])) : 32'hFF);
            chk("bounce_step", 32'(step), 32'h1);
        end

        // Blink, paused mid-pattern, then resumed.
        cycle(1'b1, 2'b11, 3'd2, 16'd3);
        for (int i = 0; i < 14; i++) cycle(1'b1, 2'b11, 3'd2, 16'd3);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 2'b11, 3'd2, 16'd3);
            chk("paused_led", 32'(led), 32'hFF);
            chk("paused_step", 32'(step), 32'h0);
        end
        for (int i = 0; i < 16; i++) cycle(1'b1, 2'b11, 3'd2, 16'd3);

        // Reset mid-chase, then time the first step after release.
        cycle(1'b1, 2'b01, 3'd5, 16'd4);
        for (int i = 0; i < 7; i++) cycle(1'b1, 2'b01, 3'd5, 16'd4);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("async_reset_led", 32'(led), 32'hFF);
        chk("async_reset_step", 32'(step), 32'h0);
        cycle(1'b1, 2'b00, 3'd0, 16'd4);
        cycle(1'b1, 2'b00, 3'd0, 16'd4);
        rst = 1'b1;
        n = 0;
        for (int i = 1; i <= 14; i++) begin
            cycle(1'b1, 2'b00, 3'd0, 16'd4);
            if (step === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("first_step_after_reset", 32'(n), 32'd5);

`ifdef LED_PWM_EN
        duty = 4'd4;
        lows = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 2'b00, 3'd0, 16'd4);
            if (led[0] === 1'b0) lows++;
        end
        chk("pwm_duty4_lows", 32'(lows), 32'd4);
`else
        lows = 0;
`endif

        // Randomized traffic with occasional mode changes, pauses and resets.
        begin
            logic [1:0]  r_md;
            logic [15:0] r_td;
            r_md = 2'b00;
            r_td = 16'd1;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 19) == 0) begin
                    r_md = 2'($urandom);
                    r_td = 16'($urandom_range(0, 4));
                end
`ifdef LED_PWM_EN
                duty = 4'($urandom);
`endif
                if ($urandom_range(0, 299) == 0) begin
                    @(negedge clk);
                    #1;
                    rst = 1'b0;
                    cycle(1'b1, r_md, 3'($urandom), r_td);
                    rst = 1'b1;
                end else begin
                    cycle(($urandom_range(0, 9) != 0), r_md, 3'($urandom), r_td);
                end
            end
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
